qdivs: RTL and testbench

QDIVS -- requirements
Module: qdivs

---
 rtl/qmath_pkg.sv | 14 +
 rtl/qdivs.sv | 113 +++++++++++
 tb/tb_qdivs.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/qmath_pkg.sv
// Shared fixed-point math definitions for the Q-format arithmetic blocks
// (qdivs, qmults): default word/fraction widths and the divider FSM encoding.
package qmath_pkg;

  localparam int QMATH_N = 32;  // total word width, sign-magnitude
  localparam int QMATH_Q = 15;  // fraction bits

  typedef enum logic [1:0] {
    QD_IDLE = 2'd0,
    QD_CALC = 2'd1,
    QD_DONE = 2'd2
  } qdiv_state_e;

endpackage

// File: rtl/qdivs.sv
// Sign-magnitude Q-format divider. Restoring long division on the operand
// magnitudes, one quotient bit per clock, MSB first. The quotient is
// truncated toward zero and saturates (with o_overflow) when it does not fit
// in N-1 magnitude bits or the divisor is zero.
module qdivs
  import qmath_pkg::*;
#(
  parameter int Q = QMATH_Q,
  parameter int N = QMATH_N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_start,
  output logic [N-1:0] o_quotient_out,
  output logic         o_complete,
  output logic         o_overflow
);

  localparam int W  = N - 1 + Q;       // working dividend / raw quotient width
  localparam int CW = $clog2(N + Q);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N + Q - 1);

  qdiv_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dvd_q;    // shifts out dividend bits, shifts in quotient bits
  logic [N-1:0]  rem_q;    // partial remainder
  logic [N-2:0]  dvs_q;    // latched divisor magnitude
  logic          sign_q;   // latched sign(dividend) ^ sign(divisor)
  logic [N-1:0]  quo_q;
  logic          cmp_q;
  logic          ovf_q;

  logic          accept;
  logic [N-1:0]  trial;
  logic [N-1:0]  diff;
  logic          fits;
  logic          q_hi;
  logic          dz;
  logic          res_ovf;
  logic [N-2:0]  res_mag;
  logic          res_sgn;

  // A start is honoured only while not dividing (IDLE or DONE).
  assign accept = i_start && (state_q != QD_CALC);

  // One restoring step: bring down the next dividend bit and try to subtract.
  assign trial = {rem_q[N-2:0], dvd_q[W-1]};
  assign fits  = (trial >= {1'b0, dvs_q});
  assign diff  = trial - {1'b0, dvs_q};

  // Final result shaping once all quotient bits are in dvd_q.
  assign q_hi    = |dvd_q[W-1:N-1];
  assign dz      = ~|dvs_q;
  assign res_ovf = q_hi | dz;
  assign res_mag = res_ovf ? {(N-1){1'b1}} : dvd_q[N-2:0];
  assign res_sgn = sign_q & (|res_mag);   // no negative zero

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= QD_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      QD_IDLE: if (accept) state_d = QD_CALC;
      QD_CALC: if (cnt_q == '0) state_d = QD_DONE;
      QD_DONE: if (accept) state_d = QD_CALC;
      default: state_d = QD_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle division step, result write-back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      sign_q <= 1'b0;
      quo_q  <= '0;
      cmp_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      cnt_q  <= CNT_LOAD;
      dvd_q  <= {i_dividend[N-2:0], {Q{1'b0}}};
      rem_q  <= '0;
      dvs_q  <= i_divisor[N-2:0];
      sign_q <= i_dividend[N-1] ^ i_divisor[N-1];
      cmp_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == QD_CALC) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
        rem_q <= fits ? diff : trial;
        dvd_q <= {dvd_q[W-2:0], fits};
      end else begin
        quo_q <= {res_sgn, res_mag};
        ovf_q <= res_ovf;
        cmp_q <= 1'b1;
      end
    end
  end

  assign o_quotient_out = quo_q;
  assign o_complete     = cmp_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_qdivs.sv
// Bench for qdivs (N=32, Q=15): fixed vector table, hand-written sequences
// for start-during-CALC and mid-operation reset, then random operands
// against an arithmetic reference model.
module tb_qdivs;

  localparam int N = 32;
  localparam int Q = 15;
  localparam int LAT = N + Q;   // edges from accepting edge to complete

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  dividend = '0;
  logic [N-1:0]  divisor = '0;
  logic          start = 1'b0;
  logic [N-1:0]  quotient;
  logic          complete;
  logic          overflow;

  int nvec = 0;
  int nmis = 0;

  qdivs #(.Q(Q), .N(N)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dividend     (dividend),
    .i_divisor      (divisor),
    .i_start        (start),
    .o_quotient_out (quotient),
    .o_complete     (complete),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer quotient of (|a| * 2^Q) / |b|, truncated.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic ovf);
    longint unsigned ma, mb, qq;
    logic [30:0] mag;
    logic        s;
    ma = 64'(a[30:0]);
    mb = 64'(b[30:0]);
    if (mb == 0) begin
      ovf = 1'b1;
      mag = '1;
    end else begin
      qq  = (ma << Q) / mb;
      ovf = (qq > 64'h7FFF_FFFF);
      mag = ovf ? 31'h7FFF_FFFF : qq[30:0];
    end
    s = (a[31] ^ b[31]) && (mag != 0);
    q = {s, mag};
  endfunction

  // Launch a divide and count edges until complete (bounded).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!complete && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  initial begin
    vec_t tbl[6];
    int lat;
    logic [31:0] eq;
    logic        eo;
    logic [31:0] prev;

    tbl[0] = '{32'h0003_0000, 32'h0001_0000, 32'h0001_8000, 1'b0};
    tbl[1] = '{32'h8003_0000, 32'h0001_0000, 32'h8001_8000, 1'b0};
    tbl[2] = '{32'h8003_0000, 32'h8001_0000, 32'h0001_8000, 1'b0};
    tbl[3] = '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0};
    tbl[5] = '{32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1};

    // Reset state
    #12;
    check("reset_quotient", 64'(quotient), 64'h0);
    check("reset_complete", 64'(complete), 64'h0);
    check("reset_overflow", 64'(overflow), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spec vectors
    for (int i = 0; i < 6; i++) begin
      do_div(tbl[i].a, tbl[i].b, lat);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("tbl%0d_quotient", i), 64'(quotient), 64'(tbl[i].q));
      check($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'(tbl[i].ovf));
    end
    // Divide by zero, negative dividend
    do_div(32'h8001_0000, 32'h0000_0000, lat);
    check("dz_latency", 64'(lat), 64'(LAT));
    check("dz_quotient", 64'(quotient), 64'hFFFF_FFFF);
    check("dz_overflow", 64'(overflow), 64'h1);

    // Start pulse and operand change during CALC are ignored
    prev = quotient;
    @(negedge clk);
    dividend = 32'h0003_0000;
    divisor  = 32'h0001_0000;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("accept_clears_complete", 64'(complete), 64'h0);
    lat = 0;
    repeat (10) begin
      @(posedge clk);
      #1 lat++;
    end
    check("calc_holds_quotient", 64'(quotient), 64'(prev));
    @(negedge clk);
    dividend = 32'h0007_0000;
    divisor  = 32'h8000_2000;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat++;
    while (!complete && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check("hold_latency", 64'(lat), 64'(LAT));
    check("hold_quotient", 64'(quotient), 64'h0001_8000);
    check("hold_overflow", 64'(overflow), 64'h0);
    repeat (3) @(posedge clk);
    #1 check("done_level_complete", 64'(complete), 64'h1);

    // Reset mid-CALC
    @(negedge clk);
    dividend = 32'h4000_0000;
    divisor  = 32'h0000_4000;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", 64'(quotient), 64'h0);
    check("midrst_complete", 64'(complete), 64'h0);
    check("midrst_overflow", 64'(overflow), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_div(32'h0000_8000, 32'h0001_8000, lat);
    check("postrst_latency", 64'(lat), 64'(LAT));
    check("postrst_quotient", 64'(quotient), 64'h0000_2AAA);
    check("postrst_overflow", 64'(overflow), 64'h0);

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case (i % 4)
        0: a = {a[31], 31'(a[30:0] >> $urandom_range(0, 30))};
        1: b = {b[31], 31'(b[30:0] >> $urandom_range(0, 30))};
        2: begin
          a = {a[31], 31'(a[30:0] >> $urandom_range(10, 30))};
          b = {b[31], 31'(b[30:0] >> $urandom_range(0, 20))};
        end
        default: if (i % 8 == 3) b = {b[31], 31'h0};
      endcase
      model(a, b, eq, eo);
      do_div(a, b, lat);
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("rnd%0d_quotient a=%h b=%h", i, a, b), 64'(quotient), 64'(eq));
      check($sformatf("rnd%0d_overflow", i), 64'(overflow), 64'(eo));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
